// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Clocked mini ALU. Operands and operation are captured on a
//               start pulse; add/subtract/pass finish after one compute
//               cycle, multiply runs a WIDTH-cycle shift-add loop. Result and
//               flags are registered and held until the next completion.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               negative
);

    localparam int              c_cw   = $clog2(WIDTH + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    localparam logic       c_idle = 1'b0;
    localparam logic       c_calc = 1'b1;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;

    logic               r_state;
    logic [1:0]         r_op;
    logic [2*WIDTH-1:0] r_a;      // operand A; doubles as the shifting multiplicand
    logic [WIDTH-1:0]   r_b;      // operand B; doubles as the shifting multiplier
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cw-1:0]    r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_quick;
    logic [2*WIDTH-1:0] w_acc_next;

    // One extra bit: carry for add, borrow (A < B) and sign for subtract.
    assign w_sum  = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a[WIDTH-1:0]} - {1'b0, r_b};

    assign busy = (r_state == c_calc);

    // Single-cycle results and the next shift-add accumulator value.
    always_comb begin
        w_acc_next = r_b[0] ? (r_acc + r_a) : r_acc;
        case (r_op)
            c_op_add: w_quick = {{(WIDTH-1){1'b0}}, w_sum};
            c_op_sub: w_quick = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            default:  w_quick = {{WIDTH{1'b0}}, r_a[WIDTH-1:0]};
        endcase
    end

    // Control FSM, operand capture, multiply loop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_op     <= 2'b00;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            done     <= 1'b0;
            result   <= '0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= {{WIDTH{1'b0}}, operand1};
                        r_b     <= operand2;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_calc;
                    end
                end
                default: begin
                    if (r_op == c_op_mul) begin
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        r_cnt <= r_cnt + c_cw'(1);
                        r_acc <= w_acc_next;
                        // Last iteration publishes the final partial sum directly.
                        if (r_cnt == c_last) begin
                            result   <= w_acc_next;
                            negative <= 1'b0;
                            done     <= 1'b1;
                            r_state  <= c_idle;
                        end
                    end else begin
                        result   <= w_quick;
                        negative <= (r_op == c_op_sub) ? w_diff[WIDTH] : 1'b0;
                        done     <= 1'b1;
                        r_state  <= c_idle;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked successor to the outreach mini ALU. Operands and operation are captured on a start pulse. Add and subtract complete in one compute cycle; multiply runs a shift-add loop over WIDTH cycles. The result and flags are registered and held until the next operation completes. The block sits between the board's switch/button inputs and the display decode path, and reports completion through a busy/done handshake.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation: 00 add, 01 subtract, 10 multiply, 11 pass operand1.
- operand1  input  WIDTH  unsigned operand A.
- operand2  input  WIDTH  unsigned operand B.
- busy  output  1  high while an operation is in progress; decoded from state.
- done  output  1  one-cycle pulse when result/negative update.
- result  output  2*WIDTH  registered result, zero-extended, except subtract.
- negative  output  1  set when a subtract has operand1 < operand2; cleared by every other completed operation.

## Operation
- States:
  - IDLE: busy=0.
  - CALC: busy=1.
- IDLE transitions:
  - start=1 on a clock edge: latch op, operand1 and operand2 into internal registers, then go to CALC.
  - start=0: stay in IDLE.
- Input sampling: after capture, changes on op and the operands have no effect until the next accepted start.
- CALC, op 00/01/11: after one cycle, write result, assert done, return to IDLE.
- CALC, op 10: run WIDTH iterations, one per cycle.
  - Each iteration: if the multiplier LSB is 1, the accumulator gains the multiplicand.
  - Then the multiplicand shifts left and the multiplier shifts right.
  - An iteration counter, ceil(log2(WIDTH+1)) bits wide, counts the iterations.
  - On the WIDTH-th iteration edge: write the accumulator to result, assert done, return to IDLE.
- Arithmetic:
  - Add: result = A + B, zero-extended to 2*WIDTH. It cannot overflow.
  - Subtract: result = A − B in two's complement, sign-extended to 2*WIDTH. negative = (A < B).
  - Multiply: result = A × B, exact in 2*WIDTH bits.
  - Pass: result = A, zero-extended.
- result and negative change only on the edge that asserts done. During CALC they hold the previous operation's values.
- start while busy=1 is ignored: no queueing, no effect on the operation in progress.
- Reset (asynchronous, any time, including mid-multiply):
  - State returns to IDLE.
  - busy, done, negative = 0; result = 0.
  - Internal operand, accumulator and counter registers are cleared.
  - The aborted operation never asserts done.

## Timing
- Edge numbering: edge 0 is the clock edge at which start is accepted.
- Latency:
  - Add/subtract/pass: result and done update at edge 1.
  - Multiply: they update at edge WIDTH.
- Handshake and pulse timing:
  - busy rises immediately after edge 0 and falls after the completing edge.
  - done is high for exactly the one cycle after the completing edge.
- Back-to-back operations:
  - The block is in IDLE during the done cycle, so start=1 in that cycle is accepted at the next edge.
  - Sustained add throughput: one result every 2 cycles.
- Simultaneous reset deassertion and start: no capture until the first clock edge with rst_n=1.

## Test plan
- Add, WIDTH=4: start with op=00, A=15, B=15.
  - Required: result=0x1E, negative=0, done at edge 1 only.
- Subtract, WIDTH=4: A=3, B=5.
  - Required: result=0xFE, negative=1.
  - Follow-up: A=5, B=3 gives result=0x02, negative=0.
- Multiply, WIDTH=4: A=15, B=15.
  - Required: busy high for 4 cycles; result stays at its old value until edge 4, then becomes 0xE1 with a single done pulse.
- Multiply at WIDTH=8: A=255, B=255.
  - Required: result=0xFE01 at edge 8.
- Busy/reset robustness:
  - Start a multiply, then re-pulse start with new operands at edge 2; the original product must complete unchanged.
  - Separately, pull rst_n low at edge 2 of a multiply. Required: result=0, busy=0, done=0 immediately, with no later done.
- Exhaustive sweep, WIDTH=4: all 256 (A,B) pairs for ops 00, 01 and 10, each start issued in the done cycle of the previous operation.
  - Every result must match a reference model.
  - Exactly one done per start.
